// File: rtl/hazard_scoreboard.sv
// Hazard unit: per-port forwarding selects, load-use/divide interlocks, stage codes, divide scoreboard.
// Latency: selects/codes combinational; div_done DIV_LAT cycles after issue. Backpressure: stalls decode/fetch on hazards.
module hazard_scoreboard #(
   parameter int NREG    = 32,
   parameter int AW      = 5,
   parameter int NRD     = 2,
   parameter int DIV_LAT = 8,
   parameter int CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               ds_valid,
   input  logic [NRD*AW-1:0]  ds_raddr,
   input  logic [AW-1:0]      ds_dest,
   input  logic               ds_div,
   input  logic               ds_go,
   input  logic               es_valid,
   input  logic               es_gr_we,
   input  logic [AW-1:0]      es_dest,
   input  logic               es_late,
   input  logic               ms_valid,
   input  logic               ms_gr_we,
   input  logic [AW-1:0]      ms_dest,
   input  logic               ws_valid,
   input  logic               ws_gr_we,
   input  logic [AW-1:0]      ws_dest,
   input  logic               flush,
   output logic [NRD*2-1:0]   ds_fwd_sel,
   output logic [1:0]         stall_f,
   output logic [1:0]         stall_d,
   output logic [1:0]         stall_e,
   output logic               div_busy,
   output logic               div_done,
   output logic [AW-1:0]      div_dest,
   output logic [CNT_W-1:0]   stall_cnt
);

   localparam int LW = 8;

   logic [NREG-1:0] pending;
   logic [NREG-1:0] pending_nxt;
   logic [LW-1:0]   counter;
   logic [NRD-1:0]  port_haz;
   logic            struct_haz;
   logic            stall;
   logic            issue;

   for (genvar i = 0; i < NRD; i++) begin : g_port
      logic [AW-1:0] a;
      logic          es_hit;
      logic          ms_hit;
      logic          ws_hit;

      assign a      = ds_raddr[i*AW +: AW];
      assign es_hit = es_valid & es_gr_we & (es_dest == a);
      assign ms_hit = ms_valid & ms_gr_we & (ms_dest == a);
      assign ws_hit = ws_valid & ws_gr_we & (ws_dest == a);

      assign ds_fwd_sel[i*2 +: 2] = (a == '0) ? 2'b00 :
                                    es_hit    ? 2'b01 :
                                    ms_hit    ? 2'b10 :
                                    ws_hit    ? 2'b11 : 2'b00;

      // A pending divide target still stalls in its done cycle; the value comes from the regfile next cycle.
      assign port_haz[i] = (a != '0) & ((es_hit & es_late) | pending[a]);
   end

   assign div_done   = div_busy & (counter == '0) & ~flush;
   assign struct_haz = ds_valid & ds_div & div_busy & ~div_done;
   assign stall      = ds_valid & ~flush & ((|port_haz) | struct_haz);
   assign issue      = ds_go & ds_div & ds_valid & ~stall & ~flush;

   always_comb begin
      stall_f = 2'b00;
      stall_d = 2'b00;
      stall_e = 2'b00;
      if (flush) begin
         stall_d = 2'b10;
         stall_e = 2'b10;
      end else if (stall) begin
         stall_f = 2'b01;
         stall_d = 2'b01;
         stall_e = 2'b10;
      end
   end

   // Retire clear and new issue set land on the same edge; set wins when dests match.
   always_comb begin
      pending_nxt = pending;
      if (div_done) pending_nxt[div_dest] = 1'b0;
      if (issue)    pending_nxt[ds_dest]  = 1'b1;
      pending_nxt[0] = 1'b0;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending  <= '0;
         counter  <= '0;
         div_busy <= 1'b0;
         div_dest <= '0;
      end else if (flush) begin
         pending  <= '0;
         counter  <= '0;
         div_busy <= 1'b0;
      end else begin
         pending <= pending_nxt;
         if (issue) begin
            div_dest <= ds_dest;
            counter  <= LW'(DIV_LAT - 1);
            div_busy <= 1'b1;
         end else if (div_done) begin
            div_busy <= 1'b0;
         end else if (div_busy) begin
            counter  <= counter - LW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         stall_cnt <= '0;
      else if (stall && (stall_cnt != '1))
         stall_cnt <= stall_cnt + CNT_W'(1);
   end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: vector table, directed multi-cycle sequences, random vs reference model.
module tb_hazard_scoreboard;

   localparam int DIV_LAT = 8;

   logic        clk, reset;
   logic        ds_valid, ds_div, ds_go, flush;
   logic [9:0]  ds_raddr;
   logic [4:0]  ds_dest, es_dest, ms_dest, ws_dest;
   logic        es_valid, es_gr_we, es_late, ms_valid, ms_gr_we, ws_valid, ws_gr_we;

   logic [3:0]  ds_fwd_sel, fwd4;
   logic [1:0]  stall_f, stall_d, stall_e, f4, d4, e4;
   logic        div_busy, div_done, busy4, done4;
   logic [4:0]  div_dest, dest4;
   logic [31:0] stall_cnt;
   logic [3:0]  cnt4;

   hazard_scoreboard #(.DIV_LAT(DIV_LAT)) dut (
      .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_raddr(ds_raddr), .ds_dest(ds_dest),
      .ds_div(ds_div), .ds_go(ds_go), .es_valid(es_valid), .es_gr_we(es_gr_we), .es_dest(es_dest),
      .es_late(es_late), .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
      .ws_valid(ws_valid), .ws_gr_we(ws_gr_we), .ws_dest(ws_dest), .flush(flush),
      .ds_fwd_sel(ds_fwd_sel), .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e),
      .div_busy(div_busy), .div_done(div_done), .div_dest(div_dest), .stall_cnt(stall_cnt));

   hazard_scoreboard #(.DIV_LAT(DIV_LAT), .CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .ds_valid(ds_valid), .ds_raddr(ds_raddr), .ds_dest(ds_dest),
      .ds_div(ds_div), .ds_go(ds_go), .es_valid(es_valid), .es_gr_we(es_gr_we), .es_dest(es_dest),
      .es_late(es_late), .ms_valid(ms_valid), .ms_gr_we(ms_gr_we), .ms_dest(ms_dest),
      .ws_valid(ws_valid), .ws_gr_we(ws_gr_we), .ws_dest(ws_dest), .flush(flush),
      .ds_fwd_sel(fwd4), .stall_f(f4), .stall_d(d4), .stall_e(e4),
      .div_busy(busy4), .div_done(done4), .div_dest(dest4), .stall_cnt(cnt4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s at %0t: got %0h, expected %0h", nm, $time, act, exp);
   endtask

   // Reference model: divide tracked by the cycle number at which it completes.
   bit      mpend[32];
   bit      minfl;
   int      mdone_at, mdest, cyc;
   longint  mcnt;
   int      mcnt4;
   logic [3:0] e_fwd;
   logic [1:0] e_f, e_d, e_e;
   bit      e_stall, e_done, e_issue;

   task automatic model_reset();
      foreach (mpend[r]) mpend[r] = 0;
      minfl = 0; mdest = 0; mcnt = 0; mcnt4 = 0;
   endtask

   task automatic model_comb();
      bit haz = 0;
      e_fwd = '0;
      for (int i = 0; i < 2; i++) begin
         int a = int'(ds_raddr[i*5 +: 5]);
         logic [1:0] s = 2'b00;
         if (a != 0) begin
            if (es_valid && es_gr_we && es_dest == a)      s = 2'b01;
            else if (ms_valid && ms_gr_we && ms_dest == a) s = 2'b10;
            else if (ws_valid && ws_gr_we && ws_dest == a) s = 2'b11;
            if ((es_valid && es_gr_we && es_late && es_dest == a) || mpend[a]) haz = 1;
         end
         e_fwd[i*2 +: 2] = s;
      end
      e_done  = minfl && (cyc == mdone_at) && !flush;
      e_stall = ds_valid && !flush && (haz || (ds_div && minfl && !e_done));
      e_issue = ds_go && ds_div && ds_valid && !e_stall && !flush;
      e_f = 2'b00; e_d = 2'b00; e_e = 2'b00;
      if (flush) begin e_d = 2'b10; e_e = 2'b10; end
      else if (e_stall) begin e_f = 2'b01; e_d = 2'b01; e_e = 2'b10; end
   endtask

   task automatic model_update();
      if (flush) begin
         foreach (mpend[r]) mpend[r] = 0;
         minfl = 0;
      end else begin
         if (e_done) begin mpend[mdest] = 0; minfl = 0; end
         if (e_issue) begin
            if (ds_dest != 0) mpend[ds_dest] = 1;
            minfl = 1; mdone_at = cyc + DIV_LAT; mdest = int'(ds_dest);
         end
      end
      if (e_stall) begin
         if (mcnt < 64'hFFFF_FFFF) mcnt++;
         if (mcnt4 < 15) mcnt4++;
      end
      cyc++;
   endtask

   // Called at posedge+1 with inputs set; compares at the falling edge.
   task automatic settle_and_check();
      #4;
      model_comb();
      chk("fwd_sel", ds_fwd_sel, e_fwd);
      chk("stall_f", stall_f, e_f);
      chk("stall_d", stall_d, e_d);
      chk("stall_e", stall_e, e_e);
      chk("div_busy", div_busy, minfl);
      chk("div_done", div_done, e_done);
      chk("div_dest", div_dest, mdest);
      chk("stall_cnt", stall_cnt, mcnt);
      chk("cnt4", cnt4, mcnt4);
      chk("dut4_outs", {fwd4, f4, d4, e4, busy4, done4, dest4},
          {e_fwd, e_f, e_d, e_e, minfl, e_done, 5'(mdest)});
   endtask

   task automatic advance();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic set_idle();
      ds_valid = 0; ds_div = 0; ds_go = 0; flush = 0; ds_raddr = '0; ds_dest = '0;
      es_valid = 0; es_gr_we = 0; es_late = 0; es_dest = '0;
      ms_valid = 0; ms_gr_we = 0; ms_dest = '0;
      ws_valid = 0; ws_gr_we = 0; ws_dest = '0;
   endtask

   task automatic issue_div9();
      set_idle();
      ds_valid = 1; ds_div = 1; ds_go = 1; ds_dest = 5'd9;
      settle_and_check();
      chk("issue_stall_d", stall_d, 2'b00);
      advance();
   endtask

   typedef struct {
      logic dv, fl, ev, ewe, elt; logic [4:0] ed;
      logic mv, mwe; logic [4:0] md;
      logic wv, wwe; logic [4:0] wd;
      logic [4:0] ra0, ra1;
      logic [3:0] fwd; logic [1:0] f, d, e; int cnt;
   } vec_t;
   vec_t tbl[$];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   initial begin
      set_idle();
      reset = 1; cyc = 0; mdone_at = 0;
      model_reset();
      @(posedge clk); #1;
      chk("rst_busy", div_busy, 1'b0);
      chk("rst_done", div_done, 1'b0);
      chk("rst_dest", div_dest, 5'd0);
      chk("rst_cnt", stall_cnt, 32'd0);
      chk("rst_cnt4", cnt4, 4'd0);
      #2 reset = 0;
      @(posedge clk); #1;

      //            dv fl ev we lt ed  mv mwe md  wv wwe wd  ra0 ra1 fwd      f  d  e  cnt
      tbl.push_back('{1, 0, 1, 1, 0, 5, 1, 1, 5, 1, 1, 5, 5, 0, 4'b0001, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 1, 0, 5, 1, 1, 5, 1, 1, 5, 5, 0, 4'b0010, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 1, 0, 5, 0, 1, 5, 1, 1, 5, 5, 0, 4'b0011, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 1, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 4'b0000, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 5, 0, 5, 4'b1100, 0, 0, 0, 0});
      tbl.push_back('{1, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0100, 1, 1, 2, 1});
      tbl.push_back('{1, 0, 0, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0000, 0, 0, 0, 1});
      tbl.push_back('{1, 1, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0100, 0, 2, 2, 1});
      tbl.push_back('{0, 0, 1, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0100, 0, 0, 0, 1});
      tbl.push_back('{1, 0, 1, 0, 1, 7, 0, 0, 0, 0, 0, 0, 0, 7, 4'b0000, 0, 0, 0, 1});
      tbl.push_back('{1, 0, 1, 1, 1, 3, 1, 1, 7, 0, 0, 0, 3, 7, 4'b1001, 1, 1, 2, 2});

      foreach (tbl[k]) begin
         set_idle();
         ds_valid = tbl[k].dv; flush = tbl[k].fl;
         es_valid = tbl[k].ev; es_gr_we = tbl[k].ewe; es_late = tbl[k].elt; es_dest = tbl[k].ed;
         ms_valid = tbl[k].mv; ms_gr_we = tbl[k].mwe; ms_dest = tbl[k].md;
         ws_valid = tbl[k].wv; ws_gr_we = tbl[k].wwe; ws_dest = tbl[k].wd;
         ds_raddr = {tbl[k].ra1, tbl[k].ra0};
         settle_and_check();
         chk($sformatf("vec%0d_fwd", k), ds_fwd_sel, tbl[k].fwd);
         chk($sformatf("vec%0d_codes", k), {stall_f, stall_d, stall_e}, {tbl[k].f, tbl[k].d, tbl[k].e});
         advance();
         chk($sformatf("vec%0d_cnt", k), stall_cnt, tbl[k].cnt);
      end

      // Divide latency with a reader of r9.
      issue_div9();
      ds_div = 0; ds_go = 0; ds_raddr = 10'd9;
      for (int k = 1; k <= 9; k++) begin
         settle_and_check();
         chk($sformatf("lat%0d_busy", k), div_busy, k <= 8);
         chk($sformatf("lat%0d_done", k), div_done, k == 8);
         chk($sformatf("lat%0d_dest", k), div_dest, 5'd9);
         chk($sformatf("lat%0d_stall_d", k), stall_d, (k <= 8) ? 2'b01 : 2'b00);
         advance();
      end

      // Back-to-back divides to the same dest.
      issue_div9();
      for (int k = 1; k <= 8; k++) begin
         settle_and_check();
         chk($sformatf("b2b%0d_stall_d", k), stall_d, (k < 8) ? 2'b01 : 2'b00);
         chk($sformatf("b2b%0d_done", k), div_done, k == 8);
         advance();
      end
      ds_div = 0; ds_go = 0; ds_raddr = 10'd9;
      for (int k = 9; k <= 17; k++) begin
         settle_and_check();
         chk($sformatf("b2b%0d_busy", k), div_busy, k <= 16);
         chk($sformatf("b2b%0d_done", k), div_done, k == 16);
         chk($sformatf("b2b%0d_stall_d", k), stall_d, (k <= 16) ? 2'b01 : 2'b00);
         advance();
      end

      // Flush three cycles after issue.
      issue_div9();
      set_idle();
      for (int k = 1; k <= 2; k++) begin settle_and_check(); advance(); end
      flush = 1; ds_valid = 1; ds_raddr = 10'd9;
      settle_and_check();
      chk("fl_codes", {stall_f, stall_d, stall_e}, 6'b00_10_10);
      chk("fl_done", div_done, 1'b0);
      advance();
      flush = 0;
      for (int k = 4; k <= 12; k++) begin
         settle_and_check();
         chk($sformatf("fl%0d_busy", k), div_busy, 1'b0);
         chk($sformatf("fl%0d_done", k), div_done, 1'b0);
         chk($sformatf("fl%0d_stall_d", k), stall_d, 2'b00);
         advance();
      end

      // Asynchronous reset between edges while a divide is in flight.
      issue_div9();
      set_idle();
      for (int k = 1; k <= 2; k++) begin settle_and_check(); advance(); end
      ds_valid = 1; ds_raddr = 10'd9;
      #2 reset = 1;
      #1;
      chk("arst_busy", div_busy, 1'b0);
      chk("arst_done", div_done, 1'b0);
      chk("arst_dest", div_dest, 5'd0);
      chk("arst_cnt", stall_cnt, 32'd0);
      chk("arst_cnt4", cnt4, 4'd0);
      chk("arst_stall_d", stall_d, 2'b00);
      #2 reset = 0;
      model_reset();
      @(posedge clk); #1;

      // Counter saturation on the 4-bit instance.
      set_idle();
      ds_valid = 1; es_valid = 1; es_gr_we = 1; es_late = 1; es_dest = 5'd7; ds_raddr = {5'd7, 5'd0};
      for (int k = 0; k < 20; k++) begin settle_and_check(); advance(); end
      chk("sat_cnt4", cnt4, 4'd15);
      chk("sat_cnt32", stall_cnt, 32'd20);

      // Randomized traffic against the reference model.
      for (int k = 0; k < 3000; k++) begin
         ds_valid = 1'($urandom_range(0, 3) != 0);
         ds_div   = 1'($urandom_range(0, 2) == 0);
         ds_go    = 1'($urandom_range(0, 3) != 0);
         flush    = 1'($urandom_range(0, 24) == 0);
         ds_raddr = {5'($urandom_range(0, 4)), 5'($urandom_range(0, 4))};
         ds_dest  = 5'($urandom_range(0, 4));
         es_valid = 1'($urandom_range(0, 1)); es_gr_we = 1'($urandom_range(0, 1));
         es_late  = 1'($urandom_range(0, 3) == 0); es_dest = 5'($urandom_range(0, 4));
         ms_valid = 1'($urandom_range(0, 1)); ms_gr_we = 1'($urandom_range(0, 1));
         ms_dest  = 5'($urandom_range(0, 4));
         ws_valid = 1'($urandom_range(0, 1)); ws_gr_we = 1'($urandom_range(0, 1));
         ws_dest  = 5'($urandom_range(0, 4));
         settle_and_check();
         advance();
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Parametrised successor to the 5-stage pipeline hazard unit.
- Generates per-read-port forwarding selects, load-use and cp0-use interlocks, and stage stall/flush codes.
- Adds a sequential scoreboard for a fixed-latency divider that writes back outside pipeline order.
- Adds a saturating stall-cycle counter.
- Sits beside the pipeline stages; consumes stage valid/dest info and drives stage control.

Parameters:
- NREG, 32, number of architectural registers; register 0 is hard-wired zero.
- AW, 5, register address width; must equal clog2(NREG).
- NRD, 2, number of decode read ports.
- DIV_LAT, 8, divider cycles from issue to writeback; legal range 2..255.
- CNT_W, 32, width of the stall counter.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-high.
- ds_valid  in  1  decode stage holds a valid instruction.
- ds_raddr  in  NRD*AW  decode read addresses; port i is at bits [i*AW +: AW].
- ds_dest  in  AW  decode destination.
- ds_div  in  1  decode instruction is a divide.
- ds_go  in  1  decode instruction advances to EX this cycle.
- es_valid, es_gr_we  in  1 each  EX stage valid / writes a register.
- es_dest  in  AW  EX destination.
- es_late  in  1  EX result not available in EX (load or mfc0).
- ms_valid, ms_gr_we  in  1 each  MEM stage valid / writes a register.
- ms_dest  in  AW  MEM destination.
- ws_valid, ws_gr_we  in  1 each  WB stage valid / writes a register.
- ws_dest  in  AW  WB destination.
- flush  in  1  exception/eret redirect.
- ds_fwd_sel  out  NRD*2  per port: 00 regfile, 01 EX, 10 MEM, 11 WB.
- stall_f, stall_d, stall_e  out  2 each  codes: 00 normal, 01 stall, 10 flush.
- div_busy  out  1  divider occupied.
- div_done  out  1  one-cycle pulse at divider writeback.
- div_dest  out  AW  destination of the in-flight divide.
- stall_cnt  out  CNT_W  count of decode-stall cycles.

Behaviour:
- Reset (asynchronous): pending[NREG-1:0]=0, counter=0, div_busy=0, div_done=0, div_dest=0, stall_cnt=0.
- Forwarding (combinational) for port i with address a!=0:
  - Priority EX > MEM > WB.
  - Select a stage when its valid and gr_we are set and its dest==a.
  - Otherwise select 00. Address 0 always selects 00.
- Hazard for port i (combinational): a!=0 and either:
  - (es_valid & es_gr_we & es_late & es_dest==a), or
  - pending[a].
- Divider structural hazard: ds_valid & ds_div & div_busy & !div_done.
- Stall: stall = ds_valid & !flush & (any port hazard | structural hazard).
- Stage codes, in priority order:
  - flush: stall_f=00, stall_d=10, stall_e=10.
  - stall: stall_f=01, stall_d=01, stall_e=10 (a bubble is injected into EX).
  - otherwise: all 00.
- Divide issue: ds_go & ds_div & ds_valid & !stall & !flush.
  - Next edge: pending[ds_dest] set (unless ds_dest==0), div_dest=ds_dest, counter=DIV_LAT-1, div_busy=1.
- While busy: counter decrements each cycle.
  - div_done is asserted combinationally when counter==0 & div_busy.
  - On that edge: pending[div_dest] cleared, div_busy=0.
- Issue in the same cycle as div_done is allowed.
  - The clear of the old dest and the set of the new dest apply together.
  - If old dest==new dest, set wins.
  - The busy flag stays 1 and the counter reloads.
- Hazard on a pending reg during its div_done cycle still stalls, so the value is read from the regfile next cycle.
- flush: on the next edge clears pending, the counter and div_busy; div_done is suppressed in a flush cycle. The divider result is discarded.
- stall_cnt: increments on each edge where the decode stall is active; saturates at all-ones.

Test Plan:
- Forwarding priority: ds_raddr port0=5; EX, MEM and WB all write r5, all valid -> ds_fwd_sel[1:0]=01. Clear EX -> 10. Clear MEM -> 11. ds_raddr=0 with all three writing r0 -> 00.
- Load-use: es_late=1, es_dest=7, ds_raddr port1=7 -> stall_f=01, stall_d=01, stall_e=10; stall_cnt goes 0->1 after one edge. Drop es_valid -> all codes 00.
- Divide latency, DIV_LAT=8: issue divide with dest=9 at cycle 0.
  - div_busy=1 for cycles 1..8; div_done pulses in cycle 8; div_dest=9.
  - A reader of r9 stalls through cycle 8 and releases in cycle 9.
- Back-to-back divide: a second divide waits until the div_done cycle, then issues in that cycle (dest 9 then 9) -> pending[9] remains set, div_busy stays 1, next div_done arrives 8 cycles later.
- Flush mid-divide: flush at cycle 3 after issue -> stall codes 00/10/10; from the next edge div_busy=0 and pending cleared; no div_done pulse.
- Reset asserted mid-divide, asynchronous and between edges -> all state zero immediately; stall_cnt=0. Saturation: CNT_W=4 with 20 stalled cycles -> stall_cnt=15.
